// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//   Digit-serial packed-BCD subtractor computing D = A - B, one decimal digit
//   per clock, least-significant digit first, with a decimal borrow chained
//   between digits. Operands holding any nibble > 9 are rejected at once.
//
//   Optional build macro: BCD_SUB_SIGN_MAG_EN
//     undefined : negative results are left as the tens complement 10^N-(B-A)
//     defined   : negative results are re-negated digit-serially (NEG state)
//                 so diff holds the magnitude; borrow still flags the sign
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request, sampled only while idle
//   a        in   [4*DIGITS] minuend, packed BCD, digit 0 in [3:0]
//   b        in   [4*DIGITS] subtrahend, packed BCD
//   diff     out  [4*DIGITS] BCD difference, held until next accepted start
//   borrow   out  1 = result negative (A < B)
//   invalid  out  1 = last request contained a non-BCD nibble
//   busy     out  1 while a subtraction is in progress
//   done     out  one-cycle completion pulse
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
  typedef enum logic [1:0] {S_IDLE, S_SUB, S_NEG} state_t;
`else
  typedef enum logic {S_IDLE, S_SUB} state_t;
`endif

  state_t        state_q;
  logic [W-1:0]  a_q, b_q, diff_q;
  logic [IW-1:0] idx_q;
  logic          bin_q;
  logic          borrow_q, invalid_q, done_q;

  logic [3:0]    min_dig, sub_dig, dig_d;
  logic [4:0]    t;
  logic          bout_d;

  function automatic logic all_bcd(input logic [W-1:0] v);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One digit of the serial subtraction; t is a 5-bit two's-complement value
  // in -10..9, so its sign bit is the outgoing borrow.
  always_comb begin
    min_dig = a_q[{idx_q, 2'b00} +: 4];
    sub_dig = b_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_SUB_SIGN_MAG_EN
    if (state_q == S_NEG) begin
      min_dig = '0;
      sub_dig = diff_q[{idx_q, 2'b00} +: 4];
    end
`endif
    t      = {1'b0, min_dig} - {1'b0, sub_dig} - {4'b0, bin_q};
    bout_d = t[4];
    dig_d  = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      bin_q     <= 1'b0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (!all_bcd(a) || !all_bcd(b)) begin
              diff_q    <= '0;
              borrow_q  <= 1'b0;
              invalid_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              a_q       <= a;
              b_q       <= b;
              idx_q     <= '0;
              bin_q     <= 1'b0;
              invalid_q <= 1'b0;
              state_q   <= S_SUB;
            end
          end
        end
        S_SUB: begin
          diff_q[{idx_q, 2'b00} +: 4] <= dig_d;
          bin_q <= bout_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            borrow_q <= bout_d;
            idx_q    <= '0;
            bin_q    <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
            if (bout_d) begin
              state_q <= S_NEG;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
`else
            state_q <= S_IDLE;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef BCD_SUB_SIGN_MAG_EN
        // Negate the tens-complement result in place: diff = 0 - diff.
        S_NEG: begin
          diff_q[{idx_q, 2'b00} +: 4] <= dig_d;
          bin_q <= bout_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            bin_q   <= 1'b0;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign diff    = diff_q;
  assign borrow  = borrow_q;
  assign invalid = invalid_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor
//   Directed-vector bench for bcd_serial_subtractor at DIGITS=4. Expected
//   results are hand-computed; sign-magnitude expectations are selected when
//   BCD_SUB_SIGN_MAG_EN is defined.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] diff;
  logic        borrow, invalid, busy, done;

  int n_vec = 0;
  int n_err = 0;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .diff    (diff),
    .borrow  (borrow),
    .invalid (invalid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one valid subtraction; optionally re-pulse start while busy.
  task automatic do_sub(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic eb, input int el, input bit poke);
    int lat;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_start"}, busy, 1'b1);
    check({tag, ".done_start"}, done, 1'b0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (poke && c == 2) begin
        start = 1'b1; a = 16'h9999; b = 16'h0000;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, ".latency"}, lat, el);
    check({tag, ".diff"}, diff, ed);
    check({tag, ".borrow"}, borrow, eb);
    check({tag, ".invalid"}, invalid, 1'b0);
    check({tag, ".busy_done"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, ".done_clear"}, done, 1'b0);
    check({tag, ".diff_hold"}, diff, ed);
  endtask

  initial begin
    int seen;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.diff", diff, 16'h0000);
    check("rst.flags", {borrow, invalid, busy, done}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_sub("basic", 16'h1234, 16'h0567, 16'h0667, 1'b0, 4, 1'b0);
`ifdef BCD_SUB_SIGN_MAG_EN
    do_sub("neg3m5", 16'h0003, 16'h0005, 16'h0002, 1'b1, 8, 1'b0);
    do_sub("negmax", 16'h0000, 16'h9999, 16'h9999, 1'b1, 8, 1'b0);
`else
    do_sub("neg3m5", 16'h0003, 16'h0005, 16'h9998, 1'b1, 4, 1'b0);
    do_sub("negmax", 16'h0000, 16'h9999, 16'h0001, 1'b1, 4, 1'b0);
`endif
    do_sub("chain", 16'h0100, 16'h0001, 16'h0099, 1'b0, 4, 1'b0);
    do_sub("max", 16'h9999, 16'h0000, 16'h9999, 1'b0, 4, 1'b0);
    do_sub("equal_poke", 16'h5000, 16'h5000, 16'h0000, 1'b0, 4, 1'b1);

    // Non-BCD nibble rejected on the accepting edge
    a = 16'h12A4; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("inv.invalid", invalid, 1'b1);
    check("inv.done", done, 1'b1);
    check("inv.diff", diff, 16'h0000);
    check("inv.borrow", borrow, 1'b0);
    check("inv.busy", busy, 1'b0);
    @(posedge clk); #1;
    check("inv.done_clear", done, 1'b0);
    check("inv.busy2", busy, 1'b0);
    check("inv.hold", invalid, 1'b1);

    // Reset at edge T+2 of an operation aborts it
    a = 16'h1234; b = 16'h0567; start = 1'b1;
    @(posedge clk); #1;             // T
    start = 1'b0;
    @(posedge clk); #1;             // T+1
    rst_n = 1'b0;
    @(posedge clk); #1;             // T+2
    check("abort.diff", diff, 16'h0000);
    check("abort.flags", {borrow, invalid, busy, done}, 4'b0000);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort.quiet", seen, 0);
    do_sub("after_abort", 16'h1234, 16'h0567, 16'h0667, 1'b0, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
